ripple_count_monitor: RTL and testbench
=======================================

// Module: ripple_count_monitor
// PURPOSE
//  Synchronous consumer of the 4-bit ripple carry counter output. Samples the
//  asynchronously settling count into the clk domain, accepts it only when it is stable,
//  and accumulates count deltas into a wide event total.
//  Flags wrap (15->0) and accumulator overflow. Sits directly downstream of the counter
//  and feeds system-level status logic.
// PARAMETERS
//  ACC_W   16      accumulator width (>=5)
//  THRESH  16'd100 accumulator threshold for irq (used only with RCM_THRESH_EN)
// PORTS
//  clk       in   1      system clock, posedge; faster than the counter's toggle rate
//  reset     in   1      asynchronous, active-high; clears all state
//  cnt_in    in   4      raw q[3:0] from ripple counter (may be mid-ripple)
//  clr       in   1      sync clear of acc/ovf/irq; baseline is kept
//  stable_q  out  4      last accepted stable count
//  valid     out  1      1 once a baseline count has been accepted
//  acc       out  ACC_W  accumulated count delta, saturating
//  wrap      out  1      1-cycle pulse when the accepted count decreases numerically
//  ovf       out  1      sticky; acc saturated
//  irq       out  1      sticky threshold flag (RCM_THRESH_EN only, else tied 0)
//  irq_ack   in   1      clears irq (RCM_THRESH_EN only, else ignored)
// BEHAVIOUR
//  - Reset (async, any time): s1, s2, stable_q, acc = 0; valid, wrap, ovf, irq = 0.
//    Reset mid-operation discards the baseline.
//  - Sampler: s1 <= cnt_in; s2 <= s1 on every posedge clk.
//  - Accept rule: sample is accepted when s1 == s2 (two consecutive equal samples).
//    Unequal samples are ignored.
//  - Latency: cnt_in held from edge n -> stable_q/acc update at edge n+3.
//  - FSM with 2 states:
//    - IDLE (after reset): first accepted sample loads stable_q, sets valid=1, no
//      accumulate, -> RUN.
//    - RUN: on accept with s2 != stable_q, delta = (s2 - stable_q) mod 16 (4-bit
//      subtract). Then acc <= acc + delta, stable_q <= s2.
//    - RUN: on accept with s2 == stable_q, nothing changes.
//  - Arithmetic: delta is 4-bit unsigned, zero-extended to ACC_W. More than 15 counter
//    steps between accepts aliases; this is a documented system constraint, not
//    detected.
//  - wrap: asserted for exactly one cycle at the update edge when s2 < old stable_q.
//  - Saturation: if acc + delta > 2^ACC_W-1, then acc <= all-ones and ovf <= 1 (sticky).
//  - clr: acc <= 0, ovf <= 0, irq <= 0. Any delta in the same cycle is discarded, but
//    stable_q still updates. wrap still pulses. clr has priority over accumulate.
//  - clr in IDLE: no effect beyond zeroing.
// CONFIGURATION
//  - RCM_THRESH_EN defined:
//    - irq <= 1 on the edge acc transitions from < THRESH to >= THRESH (including via
//      saturation).
//    - irq_ack clears irq next edge.
//    - If set and ack occur in the same cycle, set wins. clr beats both.
//  - RCM_THRESH_EN undefined: no comparator; irq tied to 0; irq_ack unused.
// STRUCTURE
//  - Shared package rcm_pkg:
//    - CNT_W=4
//    - state encodings RCM_IDLE=1'b0, RCM_RUN=1'b1
//    - function rcm_delta(new, old) returning 4-bit modular difference
//  - One sub-module: rcm_sync2 (two-flop sampler producing s1, s2 and the eq flag).
//    Accumulator, FSM and flags live in the top module.
// TESTING
//  1. Reset, hold cnt_in=4'd3 -> valid=1 at 3rd edge, stable_q=3, acc=0, wrap=0.
//  2. Baseline 3, step cnt_in to 7 then 4'd2 -> acc=4 then acc=15. wrap pulses once
//     on the 7->2 update.
//  3. Glitch: cnt_in=5 for one cycle between stable 4 and 6 -> no accept of 5, acc
//     grows by 2 only.
//  4. ACC_W=5, feed deltas totalling 40 -> acc=31, ovf=1.
//  5. clr with pending delta -> acc=0, ovf=0, stable_q=new value.
//  6. With RCM_THRESH_EN, THRESH=10:
//     - crossing 10 -> irq=1.
//     - irq_ack at the crossing cycle -> irq stays 1.
//     - later ack -> 0.
//     - reset mid-run -> all outputs 0, valid=0.

Source files
------------

// File: rtl/rcm_pkg.sv
// Shared definitions for the ripple count monitor: counter width, FSM encoding
// and the modular delta helper.
package rcm_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        RCM_IDLE = 1'b0,
        RCM_RUN  = 1'b1
    } rcm_state_e;

    // Forward distance from old_cnt to new_cnt on the 4-bit counter ring.
    function automatic logic [CNT_W-1:0] rcm_delta(input logic [CNT_W-1:0] new_cnt,
                                                   input logic [CNT_W-1:0] old_cnt);
        return new_cnt - old_cnt;
    endfunction

endpackage

// File: rtl/rcm_sync2.sv
// Two-flop sampler for the ripple counter output; eq marks two consecutive
// identical samples taken since reset.
module rcm_sync2
    import rcm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] s1,
    output logic [CNT_W-1:0] s2,
    output logic             eq
);

    // Tracks which sample flops hold a real post-reset sample, so the cleared
    // flops are never mistaken for a stable count of zero.
    logic [1:0] fill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            fill <= 2'b00;
        end else begin
            s1   <= cnt_in;
            s2   <= s1;
            fill <= {fill[0], 1'b1};
        end
    end

    assign eq = fill[1] && (s1 == s2);

endmodule

// File: rtl/ripple_count_monitor.sv
// Ripple counter consumer: accepts stable counts, accumulates deltas with saturation.
// Optional threshold interrupt enabled by defining RCM_THRESH_EN.
module ripple_count_monitor
    import rcm_pkg::*;
#(
    parameter int          ACC_W  = 16,
    parameter int unsigned THRESH = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             clr,
    output logic [CNT_W-1:0] stable_q,
    output logic             valid,
    output logic [ACC_W-1:0] acc,
    output logic             wrap,
    output logic             ovf,
    output logic             irq,
    input  logic             irq_ack
);

    logic [CNT_W-1:0] s1;
    logic [CNT_W-1:0] s2;
    logic             eq;

    rcm_sync2 u_sync (
        .clk    (clk),
        .reset  (reset),
        .cnt_in (cnt_in),
        .s1     (s1),
        .s2     (s2),
        .eq     (eq)
    );

    rcm_state_e       state_q, state_d;
    logic [CNT_W-1:0] stable_r, stable_d;
    logic             valid_r, valid_d;
    logic [ACC_W-1:0] acc_r, acc_d;
    logic             ovf_r, ovf_d;
    logic             wrap_r, wrap_d;
    logic             irq_r;
    logic [CNT_W-1:0] delta;
    logic [ACC_W:0]   sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RCM_IDLE;
            stable_r <= '0;
            valid_r  <= 1'b0;
            acc_r    <= '0;
            ovf_r    <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_r <= stable_d;
            valid_r  <= valid_d;
            acc_r    <= acc_d;
            ovf_r    <= ovf_d;
            wrap_r   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_r;
        valid_d  = valid_r;
        acc_d    = acc_r;
        ovf_d    = ovf_r;
        wrap_d   = 1'b0;
        delta    = '0;
        sum      = {1'b0, acc_r};

        if (eq) begin
            case (state_q)
                RCM_IDLE: begin
                    stable_d = s2;
                    valid_d  = 1'b1;
                    state_d  = RCM_RUN;
                end
                RCM_RUN: begin
                    if (s2 != stable_r) begin
                        delta    = rcm_delta(s2, stable_r);
                        stable_d = s2;
                        wrap_d   = (s2 < stable_r);
                        sum      = {1'b0, acc_r} + {{(ACC_W + 1 - CNT_W){1'b0}}, delta};
                        if (sum[ACC_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                    end
                end
                default: state_d = RCM_IDLE;
            endcase
        end

        // Clear drops any delta of this cycle but lets the baseline track.
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

`ifdef RCM_THRESH_EN
    localparam logic [ACC_W:0] THRESH_X = (ACC_W + 1)'(THRESH);

    logic irq_d;

    always_comb begin
        irq_d = irq_r;
        if (irq_ack)
            irq_d = 1'b0;
        if (({1'b0, acc_r} < THRESH_X) && ({1'b0, acc_d} >= THRESH_X))
            irq_d = 1'b1;
        if (clr)
            irq_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_r <= 1'b0;
        else
            irq_r <= irq_d;
    end
`else
    logic unused_thresh;
    assign unused_thresh = irq_ack ^ (THRESH == 0);
    assign irq_r = 1'b0;
`endif

    assign stable_q = stable_r;
    assign valid    = valid_r;
    assign acc      = acc_r;
    assign wrap     = wrap_r;
    assign ovf      = ovf_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Randomized bench for ripple_count_monitor: a 16-bit and a 5-bit accumulator
// instance share stimulus and are compared every cycle against a reference model.
module tb_ripple_count_monitor;

    localparam int TH = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cnt_in;
    logic       clr;
    logic       irq_ack;

    logic [3:0]  stable_a, stable_b;
    logic        valid_a, valid_b;
    logic [15:0] acc_a;
    logic [4:0]  acc_b;
    logic        wrap_a, wrap_b;
    logic        ovf_a, ovf_b;
    logic        irq_a, irq_b;

    always #5 clk = ~clk;

    ripple_count_monitor #(.ACC_W(16), .THRESH(TH)) dut (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .clr(clr),
        .stable_q(stable_a), .valid(valid_a), .acc(acc_a), .wrap(wrap_a),
        .ovf(ovf_a), .irq(irq_a), .irq_ack(irq_ack)
    );

    ripple_count_monitor #(.ACC_W(5), .THRESH(TH)) dut5 (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .clr(clr),
        .stable_q(stable_b), .valid(valid_b), .acc(acc_b), .wrap(wrap_b),
        .ovf(ovf_b), .irq(irq_b), .irq_ack(irq_ack)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: history of sampled inputs, accept on two equal samples,
    // modular deltas added to an unbounded integer and clipped per width.
    int       wid[2] = '{16, 5};
    logic [3:0] hist[$];
    bit       m_valid;
    int       m_stable;
    bit       m_wrap;
    int       macc[2];
    bit       movf[2];
    bit       mirq[2];
    int       m_d, m_old, m_new, m_max, m_nv;
    bit       m_ok;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_valid  = 1'b0;
            m_stable = 0;
            m_wrap   = 1'b0;
            for (int i = 0; i < 2; i++) begin
                macc[i] = 0;
                movf[i] = 1'b0;
                mirq[i] = 1'b0;
            end
        end else begin
            m_ok   = (hist.size() >= 2) && (hist[hist.size()-1] == hist[hist.size()-2]);
            m_nv   = (hist.size() > 0) ? int'(hist[hist.size()-1]) : 0;
            m_d    = 0;
            m_wrap = 1'b0;
            if (m_ok) begin
                if (!m_valid) begin
                    m_valid  = 1'b1;
                    m_stable = m_nv;
                end else if (m_nv != m_stable) begin
                    m_d      = (m_nv + 16 - m_stable) % 16;
                    m_wrap   = (m_nv < m_stable);
                    m_stable = m_nv;
                end
            end
            for (int i = 0; i < 2; i++) begin
                m_old = macc[i];
                m_max = (1 << wid[i]) - 1;
                m_new = m_old + m_d;
                if (m_new > m_max) begin
                    m_new   = m_max;
                    movf[i] = 1'b1;
                end
                if (clr) begin
                    m_new   = 0;
                    movf[i] = 1'b0;
                end
`ifdef RCM_THRESH_EN
                if (irq_ack) mirq[i] = 1'b0;
                if (m_old < TH && m_new >= TH) mirq[i] = 1'b1;
                if (clr) mirq[i] = 1'b0;
`endif
                macc[i] = m_new;
            end
            hist.push_back(cnt_in);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("stable_q", 32'(stable_a), 32'(m_stable));
            check("valid",    32'(valid_a),  32'(m_valid));
            check("wrap",     32'(wrap_a),   32'(m_wrap));
            check("acc16",    32'(acc_a),    32'(macc[0]));
            check("ovf16",    32'(ovf_a),    32'(movf[0]));
            check("irq16",    32'(irq_a),    32'(mirq[0]));
            check("stable5",  32'(stable_b), 32'(m_stable));
            check("valid5",   32'(valid_b),  32'(m_valid));
            check("wrap5",    32'(wrap_b),   32'(m_wrap));
            check("acc5",     32'(acc_b),    32'(macc[1]));
            check("ovf5",     32'(ovf_b),    32'(movf[1]));
            check("irq5",     32'(irq_b),    32'(mirq[1]));
        end
    end

    // Called at a negedge; leaves the bench at the negedge n cycles later.
    task automatic hold(input logic [3:0] v, input int n);
        cnt_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        cnt_in  = 4'd3;
        clr     = 1'b0;
        irq_ack = 1'b0;
        reset   = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Baseline acceptance at the third edge after reset release
        @(negedge clk);
        @(negedge clk);
        check("t1_valid_early", 32'(valid_a), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(valid_a), 32'd1);
        check("t1_stable", 32'(stable_a), 32'd3);
        check("t1_acc", 32'(acc_a), 32'd0);

        hold(4'd7, 4);
        check("t2_acc_a", 32'(acc_a), 32'd4);
        hold(4'd2, 3);
        check("t2_acc_b", 32'(acc_a), 32'd15);
        check("t2_wrap", 32'(wrap_a), 32'd1);
        @(negedge clk);
        check("t2_wrap_off", 32'(wrap_a), 32'd0);

        // Single-cycle glitch value must never be accepted
        hold(4'd4, 3);
        hold(4'd5, 1);
        hold(4'd6, 4);
        check("t3_acc", 32'(acc_a), 32'd19);
        check("t3_stable", 32'(stable_a), 32'd6);

        // Saturation of the narrow instance
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        hold(4'd5, 4);
        hold(4'd4, 4);
        hold(4'd14, 4);
        check("t4_acc5", 32'(acc_b), 32'd31);
        check("t4_ovf5", 32'(ovf_b), 32'd1);
        check("t4_acc16", 32'(acc_a), 32'd40);

        // Clear coinciding with an accepted delta
        cnt_in = 4'd9;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_acc", 32'(acc_a), 32'd0);
        check("t5_ovf5", 32'(ovf_b), 32'd0);
        check("t5_stable", 32'(stable_a), 32'd9);

`ifdef RCM_THRESH_EN
        hold(4'd13, 4);
        cnt_in = 4'd3;
        @(negedge clk);
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("t6_acc", 32'(acc_a), 32'd10);
        check("t6_irq_set_wins", 32'(irq_a), 32'd1);
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("t6_irq_ack", 32'(irq_a), 32'd0);
`endif

        do_reset();
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_acc", 32'(acc_a), 32'd0);
        check("rst_stable", 32'(stable_a), 32'd0);
        check("rst_irq", 32'(irq_a), 32'd0);

        for (int k = 0; k < 600; k++) begin
            int len;
            len    = (($urandom % 4) == 0) ? 1 : int'($urandom_range(2, 6));
            cnt_in = 4'($urandom_range(0, 15));
            for (int c = 0; c < len; c++) begin
                clr     = ($urandom_range(0, 99) < 3);
                irq_ack = ($urandom_range(0, 99) < 10);
                @(negedge clk);
            end
            clr     = 1'b0;
            irq_ack = 1'b0;
            if ($urandom_range(0, 99) < 2)
                do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
